// File: rtl/alu_writeback_stage.sv
// ALU writeback stage.
// Latches one ALU result per accepted transaction and commits it to exactly one
// target: the register-file write port, a PC-load request, or the handshaked
// output port. An ALU error, or an output consumer that never acknowledges,
// becomes a sticky exception. The stage then stops accepting work until
// exc_clear is asserted.
module alu_writeback_stage #(
    parameter logic [4:0] OP_LAST_ALU = 5'h13,
    parameter logic [4:0] OP_BEQ      = 5'h17,
    parameter logic [4:0] OP_BNE      = 5'h18,
    parameter logic [4:0] OP_OUT      = 5'h1A,
    parameter int         OUT_TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_opcode,
    input  logic [4:0]  in_dest,
    input  logic [31:0] in_result,
    input  logic        in_branch,
    input  logic        in_error,
    input  logic [31:0] in_target,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        pc_load,
    output logic [31:0] pc_value,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ack,
    output logic        exc_flag,
    output logic [4:0]  exc_code,
    input  logic        exc_clear,
    output logic [31:0] retired
);

    // The wait counter holds 0..OUT_TIMEOUT-1.
    // Keep it at least one bit wide so that tiny timeouts still elaborate.
    localparam int COUNT_W = (OUT_TIMEOUT > 2) ? $clog2(OUT_TIMEOUT) : 1;
    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(OUT_TIMEOUT - 1);

    // Exception code reported when the output consumer never acknowledges.
    localparam logic [4:0] EXC_OUT_TIMEOUT = 5'h1F;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        OUT_WAIT = 2'd2,
        HALT     = 2'd3
    } stateT;

    stateT              stateReg;
    logic [COUNT_W-1:0] waitCount;

    // Opcode decode of the incoming transaction.
    // These signals only feed registers, so the commit pulses never have a
    // combinational path from the in_* inputs.
    logic isRegWrite;
    logic isBranchOp;
    logic isOutOp;

    // Classify the incoming opcode.
    always_comb begin
        isRegWrite = (in_opcode <= OP_LAST_ALU);
        isBranchOp = (in_opcode == OP_BEQ) || (in_opcode == OP_BNE);
        isOutOp    = (in_opcode == OP_OUT);
    end

    // The stage accepts only from IDLE.
    // in_ready is also held low while reset is asserted, so upstream never
    // sees a ready that the stage cannot honour yet.
    assign in_ready = (stateReg == IDLE) && reset;

    // Control FSM with registered commit, output-port and exception outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateReg  <= IDLE;
            waitCount <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            pc_load   <= 1'b0;
            pc_value  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            exc_flag  <= 1'b0;
            exc_code  <= '0;
            retired   <= '0;
        end else begin
            // Commit strobes are single-cycle pulses unless set below.
            rf_we   <= 1'b0;
            pc_load <= 1'b0;

            case (stateReg)
                IDLE: begin
                    if (in_valid) begin
                        if (in_error) begin
                            // A faulting result is never committed.
                            stateReg <= HALT;
                            exc_flag <= 1'b1;
                            exc_code <= in_opcode;
                        end else if (isOutOp) begin
                            stateReg  <= OUT_WAIT;
                            out_valid <= 1'b1;
                            out_data  <= in_result;
                            waitCount <= '0;
                        end else begin
                            // The commit pulse and the retired count become
                            // visible together during the single COMMIT cycle.
                            // r0 is hardwired, so a write to it is suppressed
                            // but still retires.
                            stateReg <= COMMIT;
                            rf_we    <= isRegWrite && (in_dest != 5'd0);
                            rf_waddr <= in_dest;
                            rf_wdata <= in_result;
                            pc_load  <= isBranchOp && in_branch;
                            pc_value <= in_target;
                            retired  <= retired + 32'd1;
                        end
                    end
                end

                COMMIT: begin
                    stateReg <= IDLE;
                end

                OUT_WAIT: begin
                    // An acknowledge takes priority over the final timeout count.
                    if (out_ack) begin
                        out_valid <= 1'b0;
                        retired   <= retired + 32'd1;
                        stateReg  <= IDLE;
                    end else if (waitCount == COUNT_LAST) begin
                        out_valid <= 1'b0;
                        exc_flag  <= 1'b1;
                        exc_code  <= EXC_OUT_TIMEOUT;
                        stateReg  <= HALT;
                    end else begin
                        waitCount <= waitCount + COUNT_W'(1);
                    end
                end

                HALT: begin
                    // exc_code is kept after clearing for post-mortem inspection.
                    if (exc_clear) begin
                        exc_flag <= 1'b0;
                        stateReg <= IDLE;
                    end
                end

                default: begin
                    stateReg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage.
// Commit vectors are applied from a table. The handshake, timeout, error and
// reset corner cases are applied as hand-written sequences.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_alu_writeback_stage;

    localparam logic [4:0] OP_BEQ = 5'h17;
    localparam logic [4:0] OP_BNE = 5'h18;
    localparam logic [4:0] OP_OUT = 5'h1A;
    localparam int         TMO    = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [4:0]  in_dest;
    logic [31:0] in_result;
    logic        in_branch;
    logic        in_error;
    logic [31:0] in_target;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pc_load;
    logic [31:0] pc_value;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ack;
    logic        exc_flag;
    logic [4:0]  exc_code;
    logic        exc_clear;
    logic [31:0] retired;

    alu_writeback_stage #(.OUT_TIMEOUT(TMO)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_dest   (in_dest),
        .in_result (in_result),
        .in_branch (in_branch),
        .in_error  (in_error),
        .in_target (in_target),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pc_load   (pc_load),
        .pc_value  (pc_value),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ack   (out_ack),
        .exc_flag  (exc_flag),
        .exc_code  (exc_code),
        .exc_clear (exc_clear),
        .retired   (retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [4:0]  dest;
        logic [31:0] result;
        logic        branch;
        logic [31:0] target;
        logic        expWe;
        logic        expPc;
    } vecT;

    vecT         vecs[8];
    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] expRetired = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] dest, input logic [31:0] res,
                         input logic br, input logic err, input logic [31:0] tgt);
        in_valid  = 1'b1;
        in_opcode = op;
        in_dest   = dest;
        in_result = res;
        in_branch = br;
        in_error  = err;
        in_target = tgt;
    endtask

    // Applies one table vector. The bench is in IDLE at a falling edge on entry.
    task automatic runVector(input vecT v);
        check({v.name, ".ready_before"}, 32'(in_ready), 32'd1);
        drive(v.op, v.dest, v.result, v.branch, 1'b0, v.target);
        @(negedge clock);
        in_valid = 1'b0;
        expRetired = expRetired + 32'd1;
        check({v.name, ".rf_we"}, 32'(rf_we), 32'(v.expWe));
        check({v.name, ".pc_load"}, 32'(pc_load), 32'(v.expPc));
        if (v.expWe) begin
            check({v.name, ".rf_waddr"}, 32'(rf_waddr), 32'(v.dest));
            check({v.name, ".rf_wdata"}, rf_wdata, v.result);
        end
        if (v.expPc) check({v.name, ".pc_value"}, pc_value, v.target);
        check({v.name, ".retired"}, retired, expRetired);
        check({v.name, ".ready_commit"}, 32'(in_ready), 32'd0);
        @(negedge clock);
        check({v.name, ".rf_we_pulse"}, 32'(rf_we), 32'd0);
        check({v.name, ".pc_load_pulse"}, 32'(pc_load), 32'd0);
        check({v.name, ".ready_after"}, 32'(in_ready), 32'd1);
        $display("vector %s op=%0h dest=%0d rf_we=%0b pc_load=%0b retired=%0d",
                 v.name, v.op, v.dest, v.expWe, v.expPc, retired);
    endtask

    initial begin
        vecs[0] = '{"add",      5'h00, 5'd5,  32'h0000_0007, 1'b0, 32'h0,   1'b1, 1'b0};
        vecs[1] = '{"wr_r0",    5'h01, 5'd0,  32'hFFFF_FFFF, 1'b0, 32'h0,   1'b0, 1'b0};
        vecs[2] = '{"beq_take", OP_BEQ, 5'd0, 32'h0,         1'b1, 32'h40,  1'b0, 1'b1};
        vecs[3] = '{"bne_not",  OP_BNE, 5'd0, 32'h0,         1'b0, 32'h88,  1'b0, 1'b0};
        vecs[4] = '{"last_alu", 5'h13, 5'd31, 32'h1234_5678, 1'b0, 32'h0,   1'b1, 1'b0};
        vecs[5] = '{"noop_14",  5'h14, 5'd3,  32'hDEAD_BEEF, 1'b1, 32'h10,  1'b0, 1'b0};
        vecs[6] = '{"bne_take", OP_BNE, 5'd9, 32'h5555_0000, 1'b1, 32'h100, 1'b0, 1'b1};
        vecs[7] = '{"beq_dest", OP_BEQ, 5'd7, 32'h0000_00AA, 1'b1, 32'h80,  1'b0, 1'b1};

        reset = 1'b0;
        in_valid = 1'b0; in_opcode = '0; in_dest = '0; in_result = '0;
        in_branch = 1'b0; in_error = 1'b0; in_target = '0;
        out_ack = 1'b0; exc_clear = 1'b0;

        // Check the reset state.
        #12;
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.rf_we", 32'(rf_we), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.exc_flag", 32'(exc_flag), 32'd0);
        check("rst.exc_code", 32'(exc_code), 32'd0);
        check("rst.retired", retired, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst.in_ready_released", 32'(in_ready), 32'd1);

        // Apply the table-driven single-commit vectors.
        for (int i = 0; i < 8; i++) runVector(vecs[i]);

        // Back-to-back requests are accepted every other cycle.
        drive(5'h00, 5'd2, 32'h0000_0011, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            check("b2b.in_ready", 32'(in_ready), 32'((i % 2) == 0));
            check("b2b.rf_we", 32'(rf_we), 32'((i % 2) == 1));
            @(negedge clock);
        end
        in_valid = 1'b0;
        expRetired = expRetired + 32'd3;
        check("b2b.retired", retired, expRetired);
        $display("b2b three transactions retired=%0d", retired);

        // Output handshake with an acknowledge after five cycles.
        drive(OP_OUT, 5'd0, 32'h0000_CAFE, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("out.valid", 32'(out_valid), 32'd1);
            check("out.data", out_data, 32'h0000_CAFE);
            check("out.ready", 32'(in_ready), 32'd0);
            if (i == 4) out_ack = 1'b1;
            @(negedge clock);
        end
        out_ack = 1'b0;
        expRetired = expRetired + 32'd1;
        check("out.valid_drop", 32'(out_valid), 32'd0);
        check("out.retired", retired, expRetired);
        check("out.ready_after", 32'(in_ready), 32'd1);
        $display("out ack after 5 cycles retired=%0d", retired);

        // An acknowledge on the final count cycle wins over the timeout.
        drive(OP_OUT, 5'd0, 32'h0000_BEEF, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        in_valid = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            check("ackwin.valid", 32'(out_valid), 32'd1);
            if (i == TMO - 1) out_ack = 1'b1;
            @(negedge clock);
        end
        out_ack = 1'b0;
        expRetired = expRetired + 32'd1;
        check("ackwin.exc_flag", 32'(exc_flag), 32'd0);
        check("ackwin.valid_drop", 32'(out_valid), 32'd0);
        check("ackwin.retired", retired, expRetired);
        $display("out ack on last count retired=%0d", retired);

        // Output timeout with no acknowledge, followed by HALT and clear.
        drive(OP_OUT, 5'd0, 32'h0000_1234, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        in_valid = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            check("tmo.valid", 32'(out_valid), 32'd1);
            check("tmo.no_exc", 32'(exc_flag), 32'd0);
            @(negedge clock);
        end
        check("tmo.valid_drop", 32'(out_valid), 32'd0);
        check("tmo.exc_flag", 32'(exc_flag), 32'd1);
        check("tmo.exc_code", 32'(exc_code), 32'h1F);
        check("tmo.in_ready", 32'(in_ready), 32'd0);
        check("tmo.retired", retired, expRetired);
        drive(5'h00, 5'd4, 32'h99, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("halt.in_ready", 32'(in_ready), 32'd0);
            check("halt.rf_we", 32'(rf_we), 32'd0);
            check("halt.exc_flag", 32'(exc_flag), 32'd1);
        end
        in_valid = 1'b0;
        exc_clear = 1'b1;
        @(negedge clock);
        exc_clear = 1'b0;
        check("clear.exc_flag", 32'(exc_flag), 32'd0);
        check("clear.exc_code", 32'(exc_code), 32'h1F);
        check("clear.in_ready", 32'(in_ready), 32'd1);
        check("clear.retired", retired, expRetired);
        $display("out timeout halted and cleared exc_code=%0h", exc_code);

        // An ALU error on a divide halts the stage without committing.
        drive(5'h06, 5'd4, 32'h0, 1'b0, 1'b1, 32'h0);
        @(negedge clock);
        in_valid = 1'b0;
        in_error = 1'b0;
        check("err.exc_flag", 32'(exc_flag), 32'd1);
        check("err.exc_code", 32'(exc_code), 32'h06);
        check("err.rf_we", 32'(rf_we), 32'd0);
        check("err.in_ready", 32'(in_ready), 32'd0);
        check("err.retired", retired, expRetired);
        exc_clear = 1'b1;
        @(negedge clock);
        exc_clear = 1'b0;
        check("err.cleared", 32'(exc_flag), 32'd0);
        check("err.code_held", 32'(exc_code), 32'h06);
        $display("error divide exc_code=%0h", exc_code);

        // Reset during OUT_WAIT drops the transaction asynchronously.
        drive(OP_OUT, 5'd0, 32'h0000_7777, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        in_valid = 1'b0;
        check("rmid.valid_before", 32'(out_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        expRetired = 32'd0;
        check("rmid.out_valid", 32'(out_valid), 32'd0);
        check("rmid.retired", retired, expRetired);
        check("rmid.exc_code", 32'(exc_code), 32'd0);
        check("rmid.in_ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rmid.ready_after", 32'(in_ready), 32'd1);
        check("rmid.out_after", 32'(out_valid), 32'd0);
        $display("reset during out wait retired=%0d", retired);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
